// File: rtl/mux_ndff_tx.sv
// rtl/mux_ndff_tx.sv - source-side launcher for a mux + n-flop synchroniser crossing (optional MUX_NDFF_TX_ACK_EN)
// Captures a word, holds it on data_out, and pulses en_out for a HOLD window followed by a GAP guard.

module mux_ndff_tx #(
    parameter int DATA_W   = 8,
    parameter int HOLD_CYC = 4,
    parameter int GAP_CYC  = 4
) (
    input  logic              clk,
    input  logic              rstn,
`ifdef MUX_NDFF_TX_ACK_EN
    input  logic              ack_in,
`endif
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              en_out,
    output logic              busy
);

    localparam int MAX_CYC = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [DATA_W-1:0]   data_nxt;
    logic                en_nxt;
    logic                hold_release;
    logic                gap_release;

`ifdef MUX_NDFF_TX_ACK_EN
    // ack_in comes from the destination clock domain; resynchronise before use.
    logic [1:0] ack_meta;
    logic       ack_sync;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ack_meta <= 2'b00;
        end else begin
            ack_meta <= {ack_meta[0], ack_in};
        end
    end

    assign ack_sync     = ack_meta[1];
    assign hold_release = ack_sync;
    assign gap_release  = ~ack_sync;
`else
    assign hold_release = 1'b1;
    assign gap_release  = 1'b1;
`endif

    assign din_ready = (state == IDLE);
    assign busy      = ~din_ready;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        data_nxt  = data_out;
        en_nxt    = en_out;
        case (state)
            IDLE: begin
                if (din_valid) begin
                    data_nxt  = din;
                    en_nxt    = 1'b1;
                    cnt_nxt   = HOLD_LOAD;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else if (hold_release) begin
                    en_nxt    = 1'b0;
                    cnt_nxt   = GAP_LOAD;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                en_nxt = 1'b0;
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else if (gap_release) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                en_nxt    = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // data_out and en_out are plain flops so the destination sees glitch-free levels.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            cnt      <= '0;
            data_out <= '0;
            en_out   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            data_out <= data_nxt;
            en_out   <= en_nxt;
        end
    end

endmodule

// File: tb/tb_mux_ndff_tx.sv
// tb/tb_mux_ndff_tx.sv - self-checking bench for mux_ndff_tx (honours MUX_NDFF_TX_ACK_EN)
// Directed scenarios followed by random traffic, compared each cycle against a timing model.

module tb_mux_ndff_tx;

    localparam int DATA_W   = 8;
    localparam int HOLD_CYC = 4;
    localparam int GAP_CYC  = 4;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [DATA_W-1:0] din = '0;
    logic              din_valid = 1'b0;
    logic              din_ready;
    logic [DATA_W-1:0] data_out;
    logic              en_out;
    logic              busy;
    logic              ack_in = 1'b0;

    int checks   = 0;
    int failures = 0;

    // Model: phase 0 idle, 1 enable window, 2 guard gap; el = cycles spent in current phase.
    int                m_phase = 0;
    int                m_el    = 0;
    logic [DATA_W-1:0] m_data  = '0;
    logic              m_ack1  = 1'b0;
    logic              m_ack2  = 1'b0;

    always #5 clk = ~clk;

    mux_ndff_tx #(
        .DATA_W   (DATA_W),
        .HOLD_CYC (HOLD_CYC),
        .GAP_CYC  (GAP_CYC)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
`ifdef MUX_NDFF_TX_ACK_EN
        .ack_in    (ack_in),
`endif
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .data_out  (data_out),
        .en_out    (en_out),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic ack_ok_hold;
        logic ack_ok_gap;
`ifdef MUX_NDFF_TX_ACK_EN
        ack_ok_hold = m_ack2;
        ack_ok_gap  = ~m_ack2;
`else
        ack_ok_hold = 1'b1;
        ack_ok_gap  = 1'b1;
`endif
        if (!rstn) begin
            m_phase = 0;
            m_el    = 0;
            m_data  = '0;
            m_ack1  = 1'b0;
            m_ack2  = 1'b0;
        end else begin
            case (m_phase)
                0: if (din_valid) begin
                    m_data  = din;
                    m_phase = 1;
                    m_el    = 1;
                end
                1: if (m_el >= HOLD_CYC && ack_ok_hold) begin
                    m_phase = 2;
                    m_el    = 1;
                end else begin
                    m_el++;
                end
                default: if (m_el >= GAP_CYC && ack_ok_gap) begin
                    m_phase = 0;
                    m_el    = 0;
                end else begin
                    m_el++;
                end
            endcase
            m_ack2 = m_ack1;
            m_ack1 = ack_in;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("data_out", 32'(data_out), 32'(m_data));
        chk("en_out", 32'(en_out), 32'(m_phase == 1));
        chk("din_ready", 32'(din_ready), 32'(m_phase == 0));
        chk("busy", 32'(busy), 32'(m_phase != 0));
`ifdef MUX_NDFF_TX_ACK_EN
        // Destination emulation: echo the enable back, sometimes late.
        if ($urandom_range(0, 3) != 0) ack_in = en_out;
`endif
    endtask

    int en_high;
    int rdy_low;

    initial begin
        // Reset then idle
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        repeat (5) step();
        chk("idle_data", 32'(data_out), 32'h00);

        // Single word 0xA5; measure window lengths
        din = 8'hA5; din_valid = 1'b1;
        step();
        din_valid = 1'b0; din = 8'h00;
        chk("a5_captured", 32'(data_out), 32'hA5);
        en_high = 0; rdy_low = 0;
        for (int i = 0; i < 12; i++) begin
            if (en_out) en_high++;
            if (!din_ready) rdy_low++;
            step();
        end
`ifndef MUX_NDFF_TX_ACK_EN
        chk("a5_en_cycles", 32'(en_high), 32'(HOLD_CYC));
        chk("a5_busy_cycles", 32'(rdy_low), 32'(HOLD_CYC + GAP_CYC));
`endif

        // Back-to-back: 0x11 then 0x22 once ready
        din = 8'h11; din_valid = 1'b1;
        step();
        din = 8'h22;
        for (int i = 0; i < 30 && !din_ready; i++) step();
        step();
        din_valid = 1'b0;
        chk("b2b_second", 32'(data_out), 32'h22);
        repeat (10) step();

        // Busy-time word is ignored, then accepted when ready
        din = 8'h3C; din_valid = 1'b1;
        step();
        din = 8'hFF;
        for (int i = 0; i < 30 && !din_ready; i++) begin
            chk("3c_held", 32'(data_out), 32'h3C);
            step();
        end
        step();
        din_valid = 1'b0;
        chk("ff_accepted", 32'(data_out), 32'hFF);
        repeat (10) step();

        // Reset in the second HOLD cycle aborts the transfer
        din = 8'h5A; din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        step();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        chk("abort_en", 32'(en_out), 32'h0);
        chk("abort_data", 32'(data_out), 32'h00);
        chk("abort_ready", 32'(din_ready), 32'h1);
        repeat (3) step();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            din_valid = ($urandom_range(0, 1) == 1);
            din       = DATA_W'($urandom);
            rstn      = ($urandom_range(0, 59) != 0);
            step();
        end
        rstn = 1'b1;
        din_valid = 1'b0;
        repeat (20) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
